// File: rtl/ram_scan_reader_pkg.sv
// rtl/ram_scan_reader_pkg.sv - shared FSM encodings and default sizes for the RAM scan reader
package ram_scan_reader_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/ram_scan_reader_word_fifo2.sv
// rtl/ram_scan_reader_word_fifo2.sv - two-entry word FIFO catching RAM read data
module word_fifo2
    import ram_scan_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != FIFO_DEPTH) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == FIFO_DEPTH);
    assign empty   = (r_count == 2'd0);
    assign count   = r_count;

endmodule

// File: rtl/ram_scan_reader.sv
// rtl/ram_scan_reader.sv - streams COUNT consecutive RAM words out on a valid/ready port
// Optional running checksum output enabled by RAM_SCAN_READER_CHECKSUM_EN.
module ram_scan_reader
    import ram_scan_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
`ifdef RAM_SCAN_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic              out_ready
);

    localparam logic [ADDR_W:0] LEFT_ONE = (ADDR_W+1)'(1);

    scan_state_t       r_state;
    scan_state_t       w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rd_left;
    logic [ADDR_W:0]   r_out_left;
    logic              r_inflight;
    logic              w_accept;
    logic              w_rd;
    logic              w_pop;
    logic              w_room;
    logic [1:0]        w_level;
    logic [1:0]        w_fifo_cnt;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_head;

    word_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (r_inflight),
        .wr_data (mem_rdata),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_cnt)
    );

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_pop    = !w_fifo_empty && out_ready;
    // Slots committed after this edge: buffered + in flight - leaving now; never exceeds two.
    assign w_level  = w_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_room   = (w_level < FIFO_DEPTH) && !(w_fifo_full && !w_pop);

    always_comb begin
        w_next    = r_state;
        w_rd      = 1'b0;
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_FIN);
        mem_addr  = r_addr;
        out_valid = !w_fifo_empty;
        out_data  = w_head;
        case (r_state)
            ST_IDLE: begin
                // An empty scan passes through DRAIN so done lands two cycles after start.
                if (start) w_next = (count == '0) ? ST_DRAIN : ST_READ;
            end
            ST_READ: begin
                w_rd = w_room;
                if (w_room && (r_rd_left == LEFT_ONE)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((r_out_left == '0) || (w_pop && (r_out_left == LEFT_ONE))) w_next = ST_FIN;
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        mem_rd = w_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_rd_left  <= '0;
            r_out_left <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd;
            if (w_accept) begin
                r_addr     <= start_addr;
                r_rd_left  <= count;
                r_out_left <= count;
            end else begin
                if (w_rd) begin
                    r_addr    <= r_addr + 1'b1;
                    r_rd_left <= r_rd_left - 1'b1;
                end
                if (w_pop) begin
                    r_out_left <= r_out_left - 1'b1;
                end
            end
        end
    end

`ifdef RAM_SCAN_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_pop) begin
            r_sum <= r_sum + w_head;
        end
    end

    assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb/tb_ram_scan_reader.sv - directed self-checking bench for ram_scan_reader
module tb_ram_scan_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] start_addr;
    logic [14:0] count;
    logic        busy;
    logic        done;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [15:0] ram [0:16383];
    logic [15:0] got_q [$];
    logic [13:0] addr_q [$];
    int          done_seen;
    int          n_checks;
    int          n_pass;

    ram_scan_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
`ifdef RAM_SCAN_READER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic issue_start(input logic [13:0] a, input logic [14:0] n, input logic rdy);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        count      = n;
        out_ready  = rdy;
        addr_q.delete();
        got_q.delete();
    endtask

    // Runs until done (or budget), logging reads/accepted words and checking stall stability.
    task automatic run_cycles(input int budget, input logic [63:0] pat);
        logic [15:0] held;
        logic        stall;
        stall     = 1'b0;
        held      = '0;
        done_seen = 0;
        for (int k = 0; k < budget && done_seen == 0; k++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            out_ready = pat[k];
            @(negedge clk);
            if (mem_rd) addr_q.push_back(mem_addr);
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            stall = out_valid && !out_ready;
            held  = out_data;
            if (done) done_seen = 1;
        end
        check("done_seen", done_seen, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        logic [15:0] exp1 [4];
        logic [15:0] exp3 [4];
        logic [13:0] adr3 [4];
        logic [15:0] exp4 [8];
        exp1 = '{16'hA5B5, 16'hA5B4, 16'hA5B7, 16'hA5B6};
        exp3 = '{16'h9A5B, 16'h9A5A, 16'hA5A5, 16'hA5A4};
        adr3 = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        exp4 = '{16'hA585, 16'hA584, 16'hA587, 16'hA586,
                 16'hA581, 16'hA580, 16'hA583, 16'hA582};
        n_checks   = 0;
        n_pass     = 0;
        for (int a = 0; a < 16384; a++) ram[a] = 16'(a) ^ 16'hA5A5;
        ram[14'h0100] = 16'hFFFF;
        ram[14'h0101] = 16'h0002;

        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic scan: exact cycle timing with consumer always ready
        issue_start(14'h0010, 15'd4, 1'b1);
        @(negedge clk);
        check("t1_busy_at_start", busy, 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("t1_mem_rd", mem_rd, (k >= 1 && k <= 4));
            if (k <= 4) check("t1_mem_addr", mem_addr, 14'h0010 + 14'(k - 1));
            check("t1_out_valid", out_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) check("t1_out_data", out_data, exp1[k-3]);
            check("t1_done", done, (k == 7));
            check("t1_busy", busy, (k <= 7));
        end

        // Empty scan
        issue_start(14'h0123, 15'd0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("t2_mem_rd", mem_rd, 0);
            check("t2_out_valid", out_valid, 0);
            check("t2_done", done, (k == 2));
            check("t2_busy", busy, (k <= 2));
        end

        // Address wrap at the top of RAM
        issue_start(14'h3FFE, 15'd4, 1'b1);
        run_cycles(20, '1);
        check("t3_nreads", addr_q.size(), 4);
        check("t3_nwords", got_q.size(), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) check("t3_addr", addr_q[i], adr3[i]);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("t3_word", got_q[i], exp3[i]);

        // Backpressure: alternating ready then a 6-cycle stall
        issue_start(14'h0020, 15'd8, 1'b1);
        run_cycles(40, 64'hFFFF_FFFF_FFFF_C055);
        check("t4_nreads", addr_q.size(), 8);
        check("t4_nwords", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check("t4_word", got_q[i], exp4[i]);

        // Asynchronous reset while two words sit in the FIFO during DRAIN
        issue_start(14'h0040, 15'd2, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
        end
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_data", out_data, 16'hA5E5);
        check("t5_pre_addr", mem_addr, 14'h0042);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_mem_rd", mem_rd, 0);
        check("t5_rst_mem_addr", mem_addr, 0);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue_start(14'h0010, 15'd2, 1'b1);
        run_cycles(20, '1);
        check("t5_nwords", got_q.size(), 2);
        for (int i = 0; i < 2 && i < got_q.size(); i++) check("t5_word", got_q[i], exp1[i]);

`ifdef RAM_SCAN_READER_CHECKSUM_EN
        // Wrapping checksum; a start during busy must not restart the scan
        issue_start(14'h0100, 15'd2, 1'b1);
        @(posedge clk); #1;
        start_addr = 14'h0000;
        count      = 15'd5;
        @(negedge clk);
        check("t6_busy", busy, 1);
        run_cycles(20, '1);
        check("t6_nwords", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("t6_word0", got_q[0], 16'hFFFF);
            check("t6_word1", got_q[1], 16'h0002);
        end
        check("t6_checksum", checksum, 16'h0001);
        @(negedge clk);
        check("t6_checksum_hold", checksum, 16'h0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
